// File: rtl/noc_msg_merger_rr_pkg.sv
// NoC message package: flit widths, Beehive base header layout and merger state encoding.
// Shared by noc_msg_merger_rr (optional stats via NOC_MSG_MERGER_STATS_EN) and other tile arbiters.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

package noc_msg_merger_rr_pkg;

  localparam int unsigned NOC_DATA_W = `NOC_DATA_WIDTH;
  localparam int unsigned MSG_LEN_W  = `MSG_LENGTH_WIDTH;
  localparam int unsigned CHIP_ID_W  = 14;
  localparam int unsigned XY_W       = 8;
  localparam int unsigned FBITS_W    = 4;
  localparam int unsigned MSG_TYPE_W = 8;

  // Base header flit; occupies the top BASE_FLIT_W bits of a NoC flit
  typedef struct packed {
    logic [CHIP_ID_W-1:0]  dst_chip_id;
    logic [XY_W-1:0]       dst_x;
    logic [XY_W-1:0]       dst_y;
    logic [FBITS_W-1:0]    dst_fbits;
    logic [MSG_LEN_W-1:0]  msg_len;
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [CHIP_ID_W-1:0]  src_chip_id;
    logic [XY_W-1:0]       src_x;
    logic [XY_W-1:0]       src_y;
    logic [FBITS_W-1:0]    src_fbits;
  } base_noc_hdr_flit;

  localparam int unsigned BASE_FLIT_W = $bits(base_noc_hdr_flit);

  // Bit offset of msg_len inside the base header (fields below it)
  localparam int unsigned HDR_MSG_LEN_LSB = MSG_TYPE_W + CHIP_ID_W + 2 * XY_W + FBITS_W;

  typedef enum logic {
    MERGER_IDLE,
    MERGER_PASS
  } merger_state_e;

  localparam int unsigned MERGER_MAX_SRCS = 8;

  // Round-robin successor of idx among n requesters
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/noc_msg_merger_rr_rr_pick_nxt.sv
// rr_pick_nxt: combinational round-robin pick, scanning from ptr upward with wrap.
// Returns a one-hot grant, its index and whether any request is present.
module rr_pick_nxt #(
  parameter int unsigned NUM_SRCS = 4,
  parameter int unsigned SRC_W    = $clog2(NUM_SRCS)
) (
  input  logic [NUM_SRCS-1:0] req,
  input  logic [SRC_W-1:0]    ptr,
  output logic [NUM_SRCS-1:0] gnt,
  output logic [SRC_W-1:0]    idx,
  output logic                any_req
);

  int unsigned      cand;
  logic [SRC_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 32'd0;
    cand_idx = '0;
    for (int unsigned off = 0; off < NUM_SRCS; off++) begin
      cand     = (32'(ptr) + off) % NUM_SRCS;
      cand_idx = SRC_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        idx           = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

  assign any_req = found;

endmodule

// File: rtl/noc_msg_merger_rr.sv
// noc_msg_merger_rr: message-granular round-robin merge of NUM_SRCS NoC sources onto one link.
// Optional per-source message and stall counters under NOC_MSG_MERGER_STATS_EN.
module noc_msg_merger_rr
  import noc_msg_merger_rr_pkg::*;
#(
  parameter int unsigned NUM_SRCS = 4,
  parameter int unsigned DATA_W   = `NOC_DATA_WIDTH,
  parameter int unsigned SRC_W    = $clog2(NUM_SRCS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRCS-1:0]        src_noc_val,
  input  logic [NUM_SRCS*DATA_W-1:0] src_noc_data,
  output logic [NUM_SRCS-1:0]        src_noc_rdy,
  output logic                       dst_noc_val,
  output logic [DATA_W-1:0]          dst_noc_data,
  input  logic                       dst_noc_rdy,
  output logic [SRC_W-1:0]           cur_src,
  output logic                       busy
`ifdef NOC_MSG_MERGER_STATS_EN
  ,
  output logic [NUM_SRCS*32-1:0]     stat_msg_cnt,
  output logic [31:0]                stat_stall_cnt
`endif
);

  localparam int unsigned LEN_BIT = DATA_W - BASE_FLIT_W + HDR_MSG_LEN_LSB;

  merger_state_e        state;
  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     lock_src;
  logic [MSG_LEN_W-1:0] flits_left;

  logic [NUM_SRCS-1:0]  pick_gnt;
  logic [SRC_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [SRC_W-1:0]     sel_idx;
  logic [MSG_LEN_W-1:0] hdr_len;
  logic                 xfer;
  logic                 last_flit;
  logic                 hdr_only;

  logic [DATA_W-1:0]    src_flit [NUM_SRCS];

  for (genvar g = 0; g < NUM_SRCS; g++) begin : g_unpack
    assign src_flit[g] = src_noc_data[g*DATA_W +: DATA_W];
  end

  function automatic logic [SRC_W-1:0] ptr_after(input logic [SRC_W-1:0] i);
    return SRC_W'(rr_next(32'(i), NUM_SRCS));
  endfunction

  rr_pick_nxt #(
    .NUM_SRCS (NUM_SRCS),
    .SRC_W    (SRC_W)
  ) u_pick (
    .req     (src_noc_val),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  // Pass-through datapath: locked source while busy, otherwise the live pick
  assign sel_idx      = (state == MERGER_PASS) ? lock_src : pick_idx;
  assign dst_noc_data = src_flit[sel_idx];
  assign dst_noc_val  = (state == MERGER_PASS) ? src_noc_val[lock_src] : pick_any;
  assign hdr_len      = dst_noc_data[LEN_BIT +: MSG_LEN_W];

  assign xfer      = dst_noc_val && dst_noc_rdy;
  assign last_flit = (state == MERGER_PASS) && (flits_left == MSG_LEN_W'(1));
  assign hdr_only  = (state == MERGER_IDLE) && (hdr_len == '0);

  always_comb begin
    src_noc_rdy = '0;
    if (state == MERGER_PASS) begin
      src_noc_rdy[lock_src] = dst_noc_rdy;
    end else begin
      src_noc_rdy = pick_gnt & {NUM_SRCS{dst_noc_rdy}};
    end
  end

  // Message lock FSM; the pick is only committed when the header is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MERGER_IDLE;
      rr_ptr     <= '0;
      lock_src   <= '0;
      flits_left <= '0;
    end else begin
      case (state)
        MERGER_IDLE: begin
          if (xfer) begin
            if (hdr_only) begin
              rr_ptr <= ptr_after(pick_idx);
            end else begin
              state      <= MERGER_PASS;
              lock_src   <= pick_idx;
              flits_left <= hdr_len;
            end
          end
        end
        MERGER_PASS: begin
          if (xfer) begin
            flits_left <= flits_left - MSG_LEN_W'(1);
            if (last_flit) begin
              state  <= MERGER_IDLE;
              rr_ptr <= ptr_after(lock_src);
            end
          end
        end
      endcase
    end
  end

  assign busy    = (state == MERGER_PASS);
  assign cur_src = lock_src;

`ifdef NOC_MSG_MERGER_STATS_EN
  logic [NUM_SRCS-1:0][31:0] msg_cnt;
  logic [31:0]               stall_cnt;
  logic                      msg_done;

  assign msg_done = xfer && (hdr_only || last_flit);

  // Completed-message counters wrap; the stall counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (msg_done) begin
        msg_cnt[sel_idx] <= msg_cnt[sel_idx] + 32'd1;
      end
      if (dst_noc_val && !dst_noc_rdy && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign stat_msg_cnt   = msg_cnt;
  assign stat_stall_cnt = stall_cnt;
`endif

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(src_noc_rdy));
  a_lock_range: assert property (@(posedge clk) disable iff (!rst_n)
                                 busy |-> (32'(lock_src) < NUM_SRCS));

endmodule

// File: tb/tb_noc_msg_merger_rr.sv
// Directed bench for noc_msg_merger_rr; the stats scenario is built when NOC_MSG_MERGER_STATS_EN is defined.
module tb_noc_msg_merger_rr;
  import noc_msg_merger_rr_pkg::*;

  localparam int unsigned NS   = 4;
  localparam int unsigned DW   = NOC_DATA_W;
  localparam int unsigned SW   = 2;
  localparam int          MAXF = 32;
  localparam int          MAXC = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NS-1:0]      src_noc_val;
  logic [NS*DW-1:0]   src_noc_data;
  logic [NS-1:0]      src_noc_rdy;
  logic               dst_noc_val;
  logic [DW-1:0]      dst_noc_data;
  logic               dst_noc_rdy;
  logic [SW-1:0]      cur_src;
  logic               busy;
`ifdef NOC_MSG_MERGER_STATS_EN
  logic [NS*32-1:0]   stat_msg_cnt;
  logic [31:0]        stat_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Per-source flit stores, drive patterns and per-cycle logs
  logic [DW-1:0]   fl [NS][MAXF];
  int              cnt [NS];
  int              pos [NS];
  logic [MAXC-1:0] rdy_pat;
  logic [MAXC-1:0] drop [NS];
  logic [DW-1:0]   out_q [$];
  logic [NS-1:0]   rdy_log [MAXC];
  logic            busy_log [MAXC];
  logic            val_log [MAXC];
  logic [SW-1:0]   cur_log [MAXC];
  int              ncyc;
  bit              done;

  noc_msg_merger_rr #(
    .NUM_SRCS (NS),
    .DATA_W   (DW),
    .SRC_W    (SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_noc_val    (src_noc_val),
    .src_noc_data   (src_noc_data),
    .src_noc_rdy    (src_noc_rdy),
    .dst_noc_val    (dst_noc_val),
    .dst_noc_data   (dst_noc_data),
    .dst_noc_rdy    (dst_noc_rdy),
    .cur_src        (cur_src),
    .busy           (busy)
`ifdef NOC_MSG_MERGER_STATS_EN
    ,
    .stat_msg_cnt   (stat_msg_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Flit k of message m from source s; k==0 is the header carrying len
  function automatic logic [DW-1:0] mk_flit(input int s, input int m, input int k, input int len);
    base_noc_hdr_flit h;
    logic [DW-1:0]    f;
    f        = '0;
    f[31:0]  = 32'hC0DE_0000 | 32'((s << 12) | (m << 8) | k);
    if (k == 0) begin
      h          = '0;
      h.msg_len  = MSG_LEN_W'(len);
      h.msg_type = 8'h0A;
      h.dst_x    = 8'(s);
      h.src_y    = 8'hA5;
      f[DW-1 -: BASE_FLIT_W] = h;
    end
    return f;
  endfunction

  task automatic add_msg(input int s, input int m, input int len);
    for (int k = 0; k <= len; k++) begin
      fl[s][cnt[s]] = mk_flit(s, m, k, len);
      cnt[s]++;
    end
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < NS; s++) begin
      cnt[s]  = 0;
      pos[s]  = 0;
      drop[s] = '0;
    end
    rdy_pat = '1;
    out_q.delete();
  endtask

  task automatic do_reset();
    src_noc_val  = '0;
    src_noc_data = '0;
    dst_noc_rdy  = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives queued flits cycle by cycle, logging outputs at the falling edge
  task automatic run(input int max_c);
    bit all;
    done = 1'b0;
    ncyc = 0;
    for (int c = 0; c < max_c && !done; c++) begin
      for (int s = 0; s < NS; s++) begin
        src_noc_val[2'(s)]     = (pos[s] < cnt[s]) && !drop[s][6'(c)];
        src_noc_data[s*DW +: DW] = (pos[s] < cnt[s]) ? fl[s][pos[s]] : '0;
      end
      dst_noc_rdy = rdy_pat[6'(c)];
      @(negedge clk);
      rdy_log[c]  = src_noc_rdy;
      busy_log[c] = busy;
      val_log[c]  = dst_noc_val;
      cur_log[c]  = cur_src;
      if (dst_noc_val && dst_noc_rdy) out_q.push_back(dst_noc_data);
      for (int s = 0; s < NS; s++) begin
        if (src_noc_val[2'(s)] && src_noc_rdy[2'(s)]) pos[s]++;
      end
      ncyc = c + 1;
      all  = 1'b1;
      for (int s = 0; s < NS; s++) begin
        if (pos[s] < cnt[s]) all = 1'b0;
      end
      done = all;
      @(posedge clk);
      #1;
    end
    src_noc_val = '0;
    dst_noc_rdy = 1'b0;
  endtask

  task automatic test_reset();
    src_noc_val  = '0;
    src_noc_data = '0;
    dst_noc_rdy  = 1'b1;
    rst_n        = 1'b0;
    @(negedge clk);
    checks++;
    if (dst_noc_val !== 1'b0) begin errors++; $display("FAIL reset_dst_val got %b exp 0", dst_noc_val); end
    checks++;
    if (src_noc_rdy !== 4'b0000) begin errors++; $display("FAIL reset_src_rdy got %b exp 0000", src_noc_rdy); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (cur_src !== 2'd0) begin errors++; $display("FAIL reset_cur_src got %0d exp 0", cur_src); end
    do_reset();
  endtask

  task automatic test_single();
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    logic [3:0]    bl;
    do_reset();
    clear_srcs();
    add_msg(0, 0, 3);
    run(20);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done); end
    checks++;
    if (out_q.size() !== 4) begin errors++; $display("FAIL single_count got %0d exp 4", out_q.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < out_q.size()) ? out_q[k] : '0;
      exp = mk_flit(0, 0, k, 3);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", k, got[63:0], exp[63:0]); end
    end
    checks++;
    if (ncyc !== 4) begin errors++; $display("FAIL single_cycles got %0d exp 4", ncyc); end
    bl = {busy_log[3], busy_log[2], busy_log[1], busy_log[0]};
    checks++;
    if (bl !== 4'b1110) begin errors++; $display("FAIL single_busy got %b exp 1110", bl); end
    // Pointer now sits at 1: src1 beats src0 on a simultaneous request
    clear_srcs();
    add_msg(0, 1, 0);
    add_msg(1, 1, 0);
    run(10);
    got = (out_q.size() > 0) ? out_q[0] : '0;
    exp = mk_flit(1, 1, 0, 0);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL single_next_ptr got %h exp %h", got[63:0], exp[63:0]); end
    got = (out_q.size() > 1) ? out_q[1] : '0;
    exp = mk_flit(0, 1, 0, 0);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL single_next_ptr2 got %h exp %h", got[63:0], exp[63:0]); end
  endtask

  task automatic test_two_srcs();
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    logic          r2;
    do_reset();
    clear_srcs();
    add_msg(0, 0, 2);
    add_msg(2, 0, 2);
    run(20);
    checks++;
    if (ncyc !== 6) begin errors++; $display("FAIL two_cycles got %0d exp 6", ncyc); end
    for (int j = 0; j < 6; j++) begin
      got = (j < out_q.size()) ? out_q[j] : '0;
      exp = (j < 3) ? mk_flit(0, 0, j, 2) : mk_flit(2, 0, j - 3, 2);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL two_data[%0d] got %h exp %h", j, got[63:0], exp[63:0]); end
    end
    r2 = rdy_log[0][2] | rdy_log[1][2] | rdy_log[2][2];
    checks++;
    if (r2 !== 1'b0) begin errors++; $display("FAIL two_src2_rdy_during_src0 got %b exp 0", r2); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    do_reset();
    clear_srcs();
    for (int m = 0; m < 4; m++) begin
      for (int s = 1; s < 4; s++) add_msg(s, m, 0);
    end
    run(30);
    checks++;
    if (ncyc !== 12) begin errors++; $display("FAIL b2b_cycles got %0d exp 12", ncyc); end
    for (int j = 0; j < 12; j++) begin
      got = (j < out_q.size()) ? out_q[j] : '0;
      exp = mk_flit(1 + (j % 3), j / 3, 0, 0);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_grant[%0d] got %h exp %h", j, got[63:0], exp[63:0]); end
    end
  endtask

  task automatic test_stall_bubble();
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    logic          r1;
    do_reset();
    clear_srcs();
    add_msg(0, 0, 5);
    add_msg(1, 0, 0);
    rdy_pat[1] = 1'b0;
    rdy_pat[3] = 1'b0;
    drop[0][4] = 1'b1;
    drop[0][5] = 1'b1;
    run(30);
    checks++;
    if (ncyc !== 11) begin errors++; $display("FAIL stall_cycles got %0d exp 11", ncyc); end
    checks++;
    if (out_q.size() !== 7) begin errors++; $display("FAIL stall_count got %0d exp 7", out_q.size()); end
    for (int j = 0; j < 7; j++) begin
      got = (j < out_q.size()) ? out_q[j] : '0;
      exp = (j < 6) ? mk_flit(0, 0, j, 5) : mk_flit(1, 0, 0, 0);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_data[%0d] got %h exp %h", j, got[63:0], exp[63:0]); end
    end
    checks++;
    if ({val_log[5], val_log[4]} !== 2'b00) begin
      errors++; $display("FAIL stall_bubble_val got %b exp 00", {val_log[5], val_log[4]});
    end
    checks++;
    if ({busy_log[5], cur_log[5]} !== 3'b100) begin
      errors++; $display("FAIL stall_lock_held got busy %b cur %0d exp busy 1 cur 0", busy_log[5], cur_log[5]);
    end
    r1 = 1'b0;
    for (int c = 0; c < 10; c++) r1 = r1 | rdy_log[c][1];
    checks++;
    if (r1 !== 1'b0) begin errors++; $display("FAIL stall_src1_early_rdy got %b exp 0", r1); end
    checks++;
    if (rdy_log[10][1] !== 1'b1) begin errors++; $display("FAIL stall_src1_rdy_after got %b exp 1", rdy_log[10][1]); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    do_reset();
    clear_srcs();
    add_msg(1, 0, 0);
    add_msg(2, 0, 4);
    run(4);
    checks++;
    if ({busy, cur_src} !== 3'b110) begin
      errors++; $display("FAIL midrst_pre got busy %b cur %0d exp busy 1 cur 2", busy, cur_src);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++;
    if (cur_src !== 2'd0) begin errors++; $display("FAIL midrst_cur_src got %0d exp 0", cur_src); end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_srcs();
    add_msg(3, 1, 1);
    add_msg(0, 1, 0);
    run(10);
    checks++;
    if (ncyc !== 3) begin errors++; $display("FAIL midrst_cycles got %0d exp 3", ncyc); end
    for (int j = 0; j < 3; j++) begin
      got = (j < out_q.size()) ? out_q[j] : '0;
      exp = (j == 0) ? mk_flit(0, 1, 0, 0) : mk_flit(3, 1, j - 1, 1);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL midrst_data[%0d] got %h exp %h", j, got[63:0], exp[63:0]); end
    end
    checks++;
    if ({busy_log[2], cur_log[2]} !== 3'b111) begin
      errors++; $display("FAIL midrst_new_lock got busy %b cur %0d exp busy 1 cur 3", busy_log[2], cur_log[2]);
    end
  endtask

`ifdef NOC_MSG_MERGER_STATS_EN
  task automatic test_stats();
    do_reset();
    clear_srcs();
    add_msg(0, 0, 2);
    add_msg(2, 0, 2);
    rdy_pat[1] = 1'b0;
    rdy_pat[3] = 1'b0;
    rdy_pat[4] = 1'b0;
    run(20);
    checks++;
    if (ncyc !== 9) begin errors++; $display("FAIL stats_cycles got %0d exp 9", ncyc); end
    checks++;
    if (stat_msg_cnt[0*32 +: 32] !== 32'd1) begin errors++; $display("FAIL stats_msg0 got %0d exp 1", stat_msg_cnt[0*32 +: 32]); end
    checks++;
    if (stat_msg_cnt[1*32 +: 32] !== 32'd0) begin errors++; $display("FAIL stats_msg1 got %0d exp 0", stat_msg_cnt[1*32 +: 32]); end
    checks++;
    if (stat_msg_cnt[2*32 +: 32] !== 32'd1) begin errors++; $display("FAIL stats_msg2 got %0d exp 1", stat_msg_cnt[2*32 +: 32]); end
    checks++;
    if (stat_stall_cnt !== 32'd3) begin errors++; $display("FAIL stats_stall got %0d exp 3", stat_stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_two_srcs();
    test_back_to_back();
    test_stall_bubble();
    test_reset_mid();
`ifdef NOC_MSG_MERGER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
